// File: rtl/fetch_queue_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_queue_if
//  Purpose  : Bundles the fetch stage's channels: redirect from the PC stage,
//             the instruction-memory request/response channel, and the
//             instruction handshake toward decode.
//             master = fetch_queue side, slave = surrounding system.
//  Revision : 1.0  initial release
// ============================================================================
interface fetch_queue_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic                     redirect;
    logic [ADDRESS_WIDTH-1:0] redirect_pc;
    logic                     imem_req_valid;
    logic [ADDRESS_WIDTH-1:0] imem_req_addr;
    logic                     imem_req_ready;
    logic                     imem_rsp_valid;
    logic [DATA_WIDTH-1:0]    imem_rsp_data;
    logic                     inst_valid;
    logic [DATA_WIDTH-1:0]    inst_data;
    logic [ADDRESS_WIDTH-1:0] inst_pc;
    logic                     inst_ready;

    modport master (
        input  redirect, redirect_pc,
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        output inst_valid, inst_data, inst_pc,
        input  inst_ready
    );

    modport slave (
        output redirect, redirect_pc,
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        input  inst_valid, inst_data, inst_pc,
        output inst_ready
    );
endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_queue
//  Purpose  : Instruction fetch stage. Issues sequential word fetches under a
//             credit rule (queued + outstanding < DEPTH), collects in-order
//             responses into a DEPTH-entry queue tagged with their PC, and
//             hands them to decode. A redirect restarts fetching and marks
//             every in-flight response for discard.
//  Options  : FETCH_BYPASS_EN - when defined, a response arriving into an
//             empty queue is presented to decode in the same cycle.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_queue #(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       DATA_WIDTH    = 32,
    parameter int                       DEPTH         = 4,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
    input  wire logic       clk,
    input  wire logic       rst,
    fetch_queue_if.master   bus
);

    localparam int c_PTR_W  = $clog2(DEPTH);
    localparam int c_CNT_W  = c_PTR_W + 1;
    // Responses to discard can pile up across back-to-back redirects while
    // memory is slow, so this counter is wider than the credit counters.
    localparam int c_DROP_W = c_CNT_W + 8;
    localparam logic [c_CNT_W:0] c_DEPTH_V = (c_CNT_W + 1)'(DEPTH);

    // Architectural state
    logic [ADDRESS_WIDTH-1:0] r_fetch_pc;
    logic [c_PTR_W-1:0]       r_rd_ptr;
    logic [c_PTR_W-1:0]       r_wr_ptr;
    logic [c_CNT_W-1:0]       r_count;
    logic [c_CNT_W-1:0]       r_outstanding;
    logic [c_DROP_W-1:0]      r_drop;
    logic [c_PTR_W-1:0]       r_s_rd;
    logic [c_PTR_W-1:0]       r_s_wr;

    // Storage: instruction queue and side queue of outstanding request PCs
    logic [DATA_WIDTH-1:0]    r_q_data [DEPTH];
    logic [ADDRESS_WIDTH-1:0] r_q_pc   [DEPTH];
    logic [ADDRESS_WIDTH-1:0] r_s_pc   [DEPTH];

    // Combinational control
    logic                     w_credit;
    logic                     w_req_valid;
    logic                     w_accept;
    logic                     w_rsp_keep;
    logic                     w_rsp_drop;
    logic                     w_q_empty;
    logic                     w_bypass;
    logic                     w_push;
    logic                     w_deq;
    logic                     w_inst_valid;
    logic [DATA_WIDTH-1:0]    w_inst_data;
    logic [ADDRESS_WIDTH-1:0] w_inst_pc;
    logic [c_CNT_W-1:0]       w_count_nxt;
    logic [c_CNT_W-1:0]       w_out_nxt;
    logic [c_DROP_W-1:0]      w_drop_redirect;

    // Credit check, handshake decode and head-of-queue selection
    always_comb begin
        w_credit    = ({1'b0, r_count} + {1'b0, r_outstanding}) < c_DEPTH_V;
        w_req_valid = !bus.redirect && w_credit;
        w_accept    = w_req_valid && bus.imem_req_ready;
        w_rsp_drop  = bus.imem_rsp_valid && (r_drop != '0);
        w_rsp_keep  = bus.imem_rsp_valid && (r_drop == '0);
        w_q_empty   = (r_count == '0);
`ifdef FETCH_BYPASS_EN
        w_bypass    = w_q_empty && w_rsp_keep;
`else
        w_bypass    = 1'b0;
`endif
        w_inst_valid = !w_q_empty || w_bypass;
        w_inst_data  = w_bypass ? bus.imem_rsp_data : r_q_data[r_rd_ptr];
        w_inst_pc    = w_bypass ? r_s_pc[r_s_rd]     : r_q_pc[r_rd_ptr];
        // A bypassed word taken by decode never occupies a queue entry.
        w_push       = w_rsp_keep && !(w_bypass && bus.inst_ready);
        w_deq        = !bus.redirect && bus.inst_ready && !w_q_empty;
    end

    // Next-value arithmetic for the counters
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_deq})
            2'b10:   w_count_nxt = r_count + c_CNT_W'(1);
            2'b01:   w_count_nxt = r_count - c_CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
        w_out_nxt = r_outstanding;
        case ({w_accept, w_rsp_keep})
            2'b10:   w_out_nxt = r_outstanding + c_CNT_W'(1);
            2'b01:   w_out_nxt = r_outstanding - c_CNT_W'(1);
            default: w_out_nxt = r_outstanding;
        endcase
        // Every response still owed plus the pending discards, less any
        // response landing in this very cycle (it is discarded right now,
        // whether it belonged to the drop backlog or to an outstanding fetch).
        w_drop_redirect = r_drop + c_DROP_W'(r_outstanding)
                        - c_DROP_W'(bus.imem_rsp_valid);
    end

    // Pointers, counters and fetch PC; redirect flushes everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_drop        <= '0;
            r_s_rd        <= '0;
            r_s_wr        <= '0;
        end else if (bus.redirect) begin
            r_fetch_pc    <= bus.redirect_pc;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_drop        <= w_drop_redirect;
            r_s_rd        <= '0;
            r_s_wr        <= '0;
        end else begin
            if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + ADDRESS_WIDTH'(4);
                r_s_wr     <= r_s_wr + c_PTR_W'(1);
            end
            if (w_rsp_keep) begin
                r_s_rd <= r_s_rd + c_PTR_W'(1);
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_rsp_drop) begin
                r_drop <= r_drop - c_DROP_W'(1);
            end
            r_count       <= w_count_nxt;
            r_outstanding <= w_out_nxt;
        end
    end

    // Entry storage; stale contents behind the pointers are never observed
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_data[r_wr_ptr] <= bus.imem_rsp_data;
            r_q_pc[r_wr_ptr]   <= r_s_pc[r_s_rd];
        end
        if (w_accept) begin
            r_s_pc[r_s_wr] <= r_fetch_pc;
        end
    end

    // Outputs are held quiet while reset is asserted
    assign bus.imem_req_valid = w_req_valid && !rst;
    assign bus.imem_req_addr  = r_fetch_pc;
    assign bus.inst_valid     = w_inst_valid && !rst;
    assign bus.inst_data      = w_inst_data;
    assign bus.inst_pc        = w_inst_pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_queue
//  Purpose  : Directed bench for fetch_queue with an in-order memory model
//             (fixed latency, data = ~address).
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_queue;

`ifdef FETCH_BYPASS_EN
    localparam int L = 0;   // response-to-decode latency in cycles
`else
    localparam int L = 1;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   cyc;
    int   lat;
    logic [31:0] pend_addr [$];
    int          pend_due  [$];

    fetch_queue_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();

    fetch_queue #(
        .ADDRESS_WIDTH(32),
        .DATA_WIDTH   (32),
        .DEPTH        (4),
        .RESET_PC     (32'h0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: record an accepted request, then present the response due now.
    task automatic tick();
        logic        acc;
        logic [31:0] a;
        acc = bus.imem_req_valid && bus.imem_req_ready;
        a   = bus.imem_req_addr;
        @(posedge clk);
        #1;
        if (acc) begin
            pend_addr.push_back(a);
            pend_due.push_back(cyc + lat);
        end
        cyc++;
        if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = ~pend_addr[0];
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            bus.imem_rsp_valid = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.redirect       = 1'b0;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.inst_ready     = 1'b0;
        pend_addr.delete();
        pend_due.delete();
        lat = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        lat    = 1;
        rst    = 1'b1;
        bus.redirect       = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.inst_ready     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_valid",  bus.imem_req_valid, 0);
        chk("rst_inst_valid", bus.inst_valid, 0);

        // Sequential fetch, 1-cycle memory, decode always ready
        bus.inst_ready = 1'b1;
        rst = 1'b0;
        cyc = 0;
        #1;
        chk("t1_c0_req_valid", bus.imem_req_valid, 1);
        chk("t1_c0_addr",      bus.imem_req_addr, 32'h0);
        tick();
        chk("t1_c1_addr",       bus.imem_req_addr, 32'h4);
        chk("t1_c1_inst_valid", bus.inst_valid, (L == 0));
        repeat (L) tick();
        chk("t1_pc0_valid", bus.inst_valid, 1);
        chk("t1_pc0",       bus.inst_pc, 32'h0);
        chk("t1_data0",     bus.inst_data, 32'hFFFF_FFFF);
        tick();
        chk("t1_pc4",       bus.inst_pc, 32'h4);
        tick();
        chk("t1_pc8",       bus.inst_pc, 32'h8);
        chk("t1_data8",     bus.inst_data, 32'hFFFF_FFF7);

        // Credit limit: decode stalled, memory always ready
        do_reset();
        repeat (4) tick();
        chk("t2_c4_req_valid", bus.imem_req_valid, 0);
        chk("t2_c4_addr",      bus.imem_req_addr, 32'h10);
        tick();
        chk("t2_c5_req_valid", bus.imem_req_valid, 0);
        chk("t2_c5_inst_valid", bus.inst_valid, 1);
        chk("t2_c5_pc",        bus.inst_pc, 32'h0);
        bus.inst_ready = 1'b1;
        #1;
        tick();
        bus.inst_ready = 1'b0;
        #1;
        chk("t2_c6_req_valid", bus.imem_req_valid, 1);
        chk("t2_c6_addr",      bus.imem_req_addr, 32'h10);
        chk("t2_c6_pc",        bus.inst_pc, 32'h4);
        tick();
        chk("t2_c7_req_valid", bus.imem_req_valid, 0);

        // Redirect with three slow responses in flight
        do_reset();
        bus.inst_ready = 1'b1;
        lat = 5;
        repeat (3) tick();
        bus.imem_req_ready = 1'b0;
        bus.redirect       = 1'b1;
        bus.redirect_pc    = 32'h100;
        #1;
        chk("t3_redir_req_valid", bus.imem_req_valid, 0);
        tick();
        bus.redirect       = 1'b0;
        bus.imem_req_ready = 1'b1;
        #1;
        chk("t3_c4_inst_valid", bus.inst_valid, 0);
        chk("t3_c4_req_valid",  bus.imem_req_valid, 1);
        chk("t3_c4_addr",       bus.imem_req_addr, 32'h100);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t3_drop_inst_valid", bus.inst_valid, 0);
        end
        tick();
        repeat (L) tick();
        chk("t3_valid", bus.inst_valid, 1);
        chk("t3_pc",    bus.inst_pc, 32'h100);
        chk("t3_data",  bus.inst_data, 32'hFFFF_FEFF);

        // Redirect coinciding with a response and a dequeue
        do_reset();
        bus.inst_ready = 1'b1;
        repeat (2) tick();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h200;
        #1;
        chk("t4_redir_rsp_valid",  bus.imem_rsp_valid, 1);
        chk("t4_redir_inst_valid", bus.inst_valid, 1);
        tick();
        bus.redirect = 1'b0;
        #1;
        chk("t4_after_inst_valid", bus.inst_valid, 0);
        chk("t4_after_addr",       bus.imem_req_addr, 32'h200);
        tick();
        chk("t4_early_inst_valid", bus.inst_valid, (L == 0));
        repeat (L) tick();
        chk("t4_pc",   bus.inst_pc, 32'h200);
        chk("t4_data", bus.inst_data, 32'hFFFF_FDFF);
        tick();
        chk("t4_next_valid", bus.inst_valid, 1);
        chk("t4_next_pc",    bus.inst_pc, 32'h204);

        // Fetch address wrap at the top of the address space
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFC;
        #1;
        tick();
        bus.redirect = 1'b0;
        #1;
        chk("t5_req_valid",  bus.imem_req_valid, 1);
        chk("t5_addr_top",   bus.imem_req_addr, 32'hFFFF_FFFC);
        chk("t5_inst_valid", bus.inst_valid, 0);
        tick();
        chk("t5_addr_wrap",  bus.imem_req_addr, 32'h0);
        chk("t5_early_inst_valid", bus.inst_valid, (L == 0));
        repeat (L) tick();
        chk("t5_pc_top",  bus.inst_pc, 32'hFFFF_FFFC);
        tick();
        chk("t5_pc_wrap", bus.inst_pc, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
